arp_rx_cache: RTL and testbench
===============================

ARP_RX_CACHE -- requirements
Module: arp_rx_cache

Interface
REQ-001 SHALL have parameter CACHE_DEPTH, default 4 (power of 2, 2..16): number of ARP cache entries.
REQ-002 SHALL have parameter MAX_FRAME_BYTES, default 64: byte count at which reception force-terminates.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 local_ip_addr  in  32  own IPv4 address.
REQ-007 local_mac_addr  in  48  own MAC address.
REQ-008 arp_rx_req  in  1  one-cycle pulse; the first ARP payload byte arrives on or after the next cycle.
REQ-009 arp_rx_valid  in  1  arp_rx_data is valid this cycle.
REQ-010 arp_rx_data  in  8  ARP payload byte, byte 0 = HTYPE MSB.
REQ-011 arp_rx_last  in  1  qualifies the final payload byte of the frame (with arp_rx_valid).
REQ-012 crc_error  in  1  sampled in CHECK; 1 = frame bad.
REQ-013 arp_rx_end  out  1  one-cycle pulse when the frame is finished.
REQ-014 arp_reply_req / arp_reply_ack  out / in  1 / 1  reply request and its acknowledge.
REQ-015 arp_reply_ip / arp_reply_mac  out  32 / 48  requester sender IP/MAC; stable while arp_reply_req=1.
REQ-016 arp_found  out  1  one-cycle pulse: ARP reply addressed to us accepted.
REQ-017 lookup_req / lookup_ip  in  1 / 32  cache query strobe and IP.
REQ-018 lookup_ack / lookup_hit / lookup_mac  out  1 / 1 / 48  query result, one cycle after lookup_req.
REQ-019 cache_flush  in  1  clears all cache valid bits.

Function
REQ-020 FSM states SHALL be IDLE, RECV, DRAIN, CHECK, UPDATE.
- IDLE->RECV on arp_rx_req.
- RECV->CHECK on valid&last.
- RECV->DRAIN when the byte count reaches MAX_FRAME_BYTES without last.
- DRAIN->CHECK on valid&last.
- CHECK->UPDATE.
- UPDATE->IDLE.
REQ-021 An 8-bit byte counter SHALL clear in IDLE, increment only on arp_rx_valid in RECV, and saturate at 255.
REQ-022 Fields SHALL be captured at the following byte offsets:
- HTYPE 0-1, PTYPE 2-3, HLEN 4, PLEN 5, OPER 6-7
- SHA 8-13, SPA 14-17, THA 18-23, TPA 24-27
- Bytes 28 and above are ignored.
REQ-023 A frame SHALL be accepted only if all of the following hold; otherwise it is discarded with no side effects except arp_rx_end:
- crc_error=0 and not truncated;
- total bytes >= 28;
- HTYPE=0x0001, PTYPE=0x0800, HLEN=6, PLEN=4;
- OPER is 1 or 2.
REQ-024 A frame that reaches DRAIN (truncated) SHALL always be discarded.
REQ-025 arp_rx_end SHALL pulse for exactly one cycle in CHECK, for every frame.
REQ-026 arp_reply_req SHALL set in CHECK for an accepted frame with OPER=1 and TPA==local_ip_addr, loading arp_reply_ip=SPA and arp_reply_mac=SHA; it SHALL clear on the cycle after arp_reply_ack.
REQ-027 A qualifying request arriving while arp_reply_req=1 SHALL be dropped; pending reply data SHALL NOT change.
REQ-028 arp_found SHALL pulse in CHECK for an accepted frame with OPER=2, TPA==local_ip_addr and THA==local_mac_addr.
REQ-029 In UPDATE, an accepted frame SHALL write {SPA,SHA} into the cache if TPA==local_ip_addr, or if SPA already has a valid entry; it SHALL never write when SPA==0.
REQ-030 Cache write target SHALL be chosen in this priority:
- the matching valid entry (MAC overwritten);
- else the lowest-index invalid entry;
- else the entry at a log2(CACHE_DEPTH)-bit round-robin victim pointer, which then increments and wraps to 0.
REQ-031 Lookup SHALL have 1-cycle latency: lookup_ack=1 the cycle after lookup_req. If hit, lookup_hit=1 and lookup_mac holds the entry MAC; if miss, lookup_hit=0 and lookup_mac=0.
REQ-032 A lookup coincident with an UPDATE write SHALL return pre-write contents.
REQ-033 cache_flush SHALL clear all valid bits and the victim pointer next cycle, and SHALL take priority over a same-cycle UPDATE write.
REQ-034 arp_rx_req seen outside IDLE SHALL be ignored.

Reset
REQ-035 On rst=1, all of the following SHALL clear asynchronously:
- FSM to IDLE, counter 0, all captured fields 0;
- all cache valid bits and the victim pointer 0;
- every output 0.
REQ-036 A frame in progress at reset SHALL be abandoned with no arp_rx_end, and a pending arp_reply_req SHALL be cleared.

Verification
REQ-037 Valid request, TPA=local_ip, SPA=C0A80002, SHA=001122334455 -> the following are all observed:
- arp_rx_end pulses once;
- arp_reply_req=1 with arp_reply_ip=C0A80002;
- ack clears it next cycle;
- cache holds that entry;
- lookup C0A80002 returns hit with 001122334455 one cycle later.
REQ-038 Reply with OPER=2, TPA/THA=local, crc_error=1 -> arp_rx_end only; no arp_found, no cache write.
REQ-039 With CACHE_DEPTH=4, CACHE_DEPTH+2 distinct valid requests -> entries 0..3 filled in order; the 5th overwrites entry 0, the 6th entry 1.
REQ-040 Frame with PTYPE=0x86DD, or 20 bytes then last -> discarded, arp_rx_end pulses; a 70-byte frame without early last enters DRAIN and is discarded.
REQ-041 Second request while arp_reply_req is pending -> arp_reply_ip unchanged. Separately, rst asserted mid-RECV -> all outputs 0 and no arp_rx_end.

Source files
------------

// File: rtl/arp_rx_cache.sv
// ARP receive parser with a small IPv4-to-MAC cache.
// Parses one ARP payload per frame, raises reply/found events and learns sender bindings.
module arp_rx_cache #(
  parameter int unsigned CACHE_DEPTH     = 4,
  parameter int unsigned MAX_FRAME_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] local_ip_addr,
  input  logic [47:0] local_mac_addr,
  input  logic        arp_rx_req,
  input  logic        arp_rx_valid,
  input  logic [7:0]  arp_rx_data,
  input  logic        arp_rx_last,
  input  logic        crc_error,
  output logic        arp_rx_end,
  output logic        arp_reply_req,
  input  logic        arp_reply_ack,
  output logic [31:0] arp_reply_ip,
  output logic [47:0] arp_reply_mac,
  output logic        arp_found,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_ack,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac,
  input  logic        cache_flush
);

  localparam int unsigned IdxW    = $clog2(CACHE_DEPTH);
  localparam logic [7:0]  LastCnt = 8'(MAX_FRAME_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StRecv, StDrain, StCheck, StUpdate} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        trunc_q, trunc_d;
  logic        accept_q, accept_d;
  logic [15:0] htype_q, htype_d, ptype_q, ptype_d, oper_q, oper_d;
  logic [7:0]  hlen_q, hlen_d, plen_q, plen_d;
  logic [47:0] sha_q, sha_d, tha_q, tha_d;
  logic [31:0] spa_q, spa_d, tpa_q, tpa_d;

  logic        reply_req_q, reply_req_d;
  logic [31:0] reply_ip_q, reply_ip_d;
  logic [47:0] reply_mac_q, reply_mac_d;
  logic        lookup_ack_q, lookup_ack_d, lookup_hit_q, lookup_hit_d;
  logic [47:0] lookup_mac_q, lookup_mac_d;

  logic [CACHE_DEPTH-1:0] valid_q, valid_d;
  logic [31:0]            cip_q  [CACHE_DEPTH];
  logic [31:0]            cip_d  [CACHE_DEPTH];
  logic [47:0]            cmac_q [CACHE_DEPTH];
  logic [47:0]            cmac_d [CACHE_DEPTH];
  logic [IdxW-1:0]        victim_q, victim_d;

  logic            frame_ok, to_us, spa_hit, free_found, lk_hit, wr_en;
  logic [IdxW-1:0] spa_idx, free_idx, wr_idx;
  logic [47:0]     lk_mac;

  assign frame_ok = !crc_error && !trunc_q && (cnt_q >= 8'd28) &&
                    (htype_q == 16'h0001) && (ptype_q == 16'h0800) &&
                    (hlen_q == 8'd6) && (plen_q == 8'd4) &&
                    ((oper_q == 16'd1) || (oper_q == 16'd2));
  assign to_us    = (tpa_q == local_ip_addr);

  assign arp_rx_end    = (state_q == StCheck);
  assign arp_found     = (state_q == StCheck) && frame_ok && (oper_q == 16'd2) && to_us &&
                         (tha_q == local_mac_addr);
  assign arp_reply_req = reply_req_q;
  assign arp_reply_ip  = reply_ip_q;
  assign arp_reply_mac = reply_mac_q;
  assign lookup_ack    = lookup_ack_q;
  assign lookup_hit    = lookup_hit_q;
  assign lookup_mac    = lookup_mac_q;

  // Cache searches read only registered contents, so a lookup sees pre-write data.
  always_comb begin
    spa_hit    = 1'b0;
    spa_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    lk_hit     = 1'b0;
    lk_mac     = '0;
    for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
      if (valid_q[i] && (cip_q[i] == spa_q)) begin
        spa_hit = 1'b1;
        spa_idx = IdxW'(i);
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      if (valid_q[i] && (cip_q[i] == lookup_ip)) begin
        lk_hit = 1'b1;
        lk_mac = cmac_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trunc_d     = trunc_q;
    accept_d    = accept_q;
    htype_d     = htype_q;
    ptype_d     = ptype_q;
    hlen_d      = hlen_q;
    plen_d      = plen_q;
    oper_d      = oper_q;
    sha_d       = sha_q;
    spa_d       = spa_q;
    tha_d       = tha_q;
    tpa_d       = tpa_q;
    reply_req_d = reply_req_q;
    reply_ip_d  = reply_ip_q;
    reply_mac_d = reply_mac_q;

    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        trunc_d = 1'b0;
        if (arp_rx_req) state_d = StRecv;
      end
      StRecv: begin
        if (arp_rx_valid) begin
          cnt_d = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
          if (cnt_q < 8'd2)       htype_d = {htype_q[7:0], arp_rx_data};
          else if (cnt_q < 8'd4)  ptype_d = {ptype_q[7:0], arp_rx_data};
          else if (cnt_q == 8'd4) hlen_d  = arp_rx_data;
          else if (cnt_q == 8'd5) plen_d  = arp_rx_data;
          else if (cnt_q < 8'd8)  oper_d  = {oper_q[7:0], arp_rx_data};
          else if (cnt_q < 8'd14) sha_d   = {sha_q[39:0], arp_rx_data};
          else if (cnt_q < 8'd18) spa_d   = {spa_q[23:0], arp_rx_data};
          else if (cnt_q < 8'd24) tha_d   = {tha_q[39:0], arp_rx_data};
          else if (cnt_q < 8'd28) tpa_d   = {tpa_q[23:0], arp_rx_data};
          if (arp_rx_last) begin
            state_d = StCheck;
          end else if (cnt_q == LastCnt) begin
            state_d = StDrain;
            trunc_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (arp_rx_valid && arp_rx_last) state_d = StCheck;
      end
      StCheck: begin
        accept_d = frame_ok;
        // A request arriving while a reply is still pending is dropped.
        if (frame_ok && (oper_q == 16'd1) && to_us && !reply_req_q) begin
          reply_req_d = 1'b1;
          reply_ip_d  = spa_q;
          reply_mac_d = sha_q;
        end
        state_d = StUpdate;
      end
      StUpdate: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (reply_req_q && arp_reply_ack) reply_req_d = 1'b0;
  end

  always_comb begin
    valid_d  = valid_q;
    cip_d    = cip_q;
    cmac_d   = cmac_q;
    victim_d = victim_q;
    wr_idx   = victim_q;
    wr_en    = (state_q == StUpdate) && accept_q && (spa_q != 32'd0) && (to_us || spa_hit);
    if (spa_hit)         wr_idx = spa_idx;
    else if (free_found) wr_idx = free_idx;

    if (cache_flush) begin
      valid_d  = '0;
      victim_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      cip_d[wr_idx]   = spa_q;
      cmac_d[wr_idx]  = sha_q;
      if (!spa_hit && !free_found) victim_d = victim_q + IdxW'(1);
    end

    lookup_ack_d = lookup_req;
    lookup_hit_d = lookup_req && lk_hit;
    lookup_mac_d = (lookup_req && lk_hit) ? lk_mac : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      trunc_q      <= 1'b0;
      accept_q     <= 1'b0;
      htype_q      <= '0;
      ptype_q      <= '0;
      hlen_q       <= '0;
      plen_q       <= '0;
      oper_q       <= '0;
      sha_q        <= '0;
      spa_q        <= '0;
      tha_q        <= '0;
      tpa_q        <= '0;
      reply_req_q  <= 1'b0;
      reply_ip_q   <= '0;
      reply_mac_q  <= '0;
      lookup_ack_q <= 1'b0;
      lookup_hit_q <= 1'b0;
      lookup_mac_q <= '0;
      valid_q      <= '0;
      victim_q     <= '0;
      for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
        cip_q[i]  <= '0;
        cmac_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trunc_q      <= trunc_d;
      accept_q     <= accept_d;
      htype_q      <= htype_d;
      ptype_q      <= ptype_d;
      hlen_q       <= hlen_d;
      plen_q       <= plen_d;
      oper_q       <= oper_d;
      sha_q        <= sha_d;
      spa_q        <= spa_d;
      tha_q        <= tha_d;
      tpa_q        <= tpa_d;
      reply_req_q  <= reply_req_d;
      reply_ip_q   <= reply_ip_d;
      reply_mac_q  <= reply_mac_d;
      lookup_ack_q <= lookup_ack_d;
      lookup_hit_q <= lookup_hit_d;
      lookup_mac_q <= lookup_mac_d;
      valid_q      <= valid_d;
      victim_q     <= victim_d;
      cip_q        <= cip_d;
      cmac_q       <= cmac_d;
    end
  end

endmodule

// File: tb/tb_arp_rx_cache.sv
// Bench for arp_rx_cache: directed ARP frames, expected events queued and checked by a monitor.
module tb_arp_rx_cache;

  localparam logic [31:0] MyIp  = 32'hC0A80001;
  localparam logic [47:0] MyMac = 48'h020000000001;
  localparam int KEnd = 0, KFound = 1, KReply = 2, KLook = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] local_ip_addr;
  logic [47:0] local_mac_addr;
  logic        arp_rx_req, arp_rx_valid, arp_rx_last, crc_error;
  logic [7:0]  arp_rx_data;
  logic        arp_rx_end, arp_reply_req, arp_reply_ack, arp_found;
  logic [31:0] arp_reply_ip;
  logic [47:0] arp_reply_mac;
  logic        lookup_req, lookup_ack, lookup_hit, cache_flush;
  logic [31:0] lookup_ip;
  logic [47:0] lookup_mac;

  always #5 clk = ~clk;

  arp_rx_cache #(.CACHE_DEPTH(4), .MAX_FRAME_BYTES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .local_ip_addr (local_ip_addr),
    .local_mac_addr(local_mac_addr),
    .arp_rx_req    (arp_rx_req),
    .arp_rx_valid  (arp_rx_valid),
    .arp_rx_data   (arp_rx_data),
    .arp_rx_last   (arp_rx_last),
    .crc_error     (crc_error),
    .arp_rx_end    (arp_rx_end),
    .arp_reply_req (arp_reply_req),
    .arp_reply_ack (arp_reply_ack),
    .arp_reply_ip  (arp_reply_ip),
    .arp_reply_mac (arp_reply_mac),
    .arp_found     (arp_found),
    .lookup_req    (lookup_req),
    .lookup_ip     (lookup_ip),
    .lookup_ack    (lookup_ack),
    .lookup_hit    (lookup_hit),
    .lookup_mac    (lookup_mac),
    .cache_flush   (cache_flush)
  );

  typedef struct {
    int          kind;
    logic [47:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  logic       req_prev;
  logic [7:0] fb [80];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input int kind, input logic [47:0] a, input logic [31:0] b);
    exp_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [47:0] a, input logic [31:0] b);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d a=%h b=%h expected none", kind, a, b);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.a !== a || e.b !== b) begin
        bad++;
        $display("FAIL event: got kind=%0d a=%h b=%h expected kind=%0d a=%h b=%h",
                 kind, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Fixed in-cycle order: end, found, reply rise, lookup ack.
  always @(negedge clk) begin
    if (rst) begin
      req_prev <= 1'b0;
    end else begin
      if (arp_rx_end) sb_check(KEnd, 48'h0, 32'h0);
      if (arp_found) sb_check(KFound, 48'h0, 32'h0);
      if (arp_reply_req && !req_prev) sb_check(KReply, arp_reply_mac, arp_reply_ip);
      if (lookup_ack) sb_check(KLook, lookup_mac, {31'b0, lookup_hit});
      req_prev <= arp_reply_req;
    end
  end

  task automatic build(input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                       input logic [47:0] tha, input logic [31:0] tpa, input logic [15:0] ptype);
    for (int i = 0; i < 80; i++) fb[i] = 8'h00;
    fb[1] = 8'h01;
    fb[2] = ptype[15:8];
    fb[3] = ptype[7:0];
    fb[4] = 8'h06;
    fb[5] = 8'h04;
    fb[6] = oper[15:8];
    fb[7] = oper[7:0];
    for (int i = 0; i < 6; i++) begin
      fb[8 + i]  = sha[47 - 8*i -: 8];
      fb[18 + i] = tha[47 - 8*i -: 8];
    end
    for (int i = 0; i < 4; i++) begin
      fb[14 + i] = spa[31 - 8*i -: 8];
      fb[24 + i] = tpa[31 - 8*i -: 8];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int n);
    arp_rx_req = 1'b1;
    idle(1);
    arp_rx_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      arp_rx_valid = 1'b1;
      arp_rx_data  = fb[i];
      arp_rx_last  = (i == n - 1);
      idle(1);
    end
    arp_rx_valid = 1'b0;
    arp_rx_last  = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] ip);
    lookup_req = 1'b1;
    lookup_ip  = ip;
    idle(1);
    lookup_req = 1'b0;
  endtask

  task automatic ack_reply();
    arp_reply_ack = 1'b1;
    idle(1);
    arp_reply_ack = 1'b0;
    check("reply_req_cleared_after_ack", {63'b0, arp_reply_req}, 64'h0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_end"}, {63'b0, arp_rx_end}, 64'h0);
    check({tag, "_reply_req"}, {63'b0, arp_reply_req}, 64'h0);
    check({tag, "_reply_ip"}, {32'b0, arp_reply_ip}, 64'h0);
    check({tag, "_reply_mac"}, {16'b0, arp_reply_mac}, 64'h0);
    check({tag, "_found"}, {63'b0, arp_found}, 64'h0);
    check({tag, "_lookup_ack"}, {63'b0, lookup_ack}, 64'h0);
    check({tag, "_lookup_hit"}, {63'b0, lookup_hit}, 64'h0);
    check({tag, "_lookup_mac"}, {16'b0, lookup_mac}, 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    local_ip_addr = MyIp;
    local_mac_addr = MyMac;
    arp_rx_req = 1'b0;
    arp_rx_valid = 1'b0;
    arp_rx_last = 1'b0;
    arp_rx_data = 8'h00;
    crc_error = 1'b0;
    arp_reply_ack = 1'b0;
    lookup_req = 1'b0;
    lookup_ip = 32'h0;
    cache_flush = 1'b0;
    idle(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);

    // Request to us: reply raised, lookup during UPDATE sees pre-write cache.
    build(16'd1, 48'h001122334455, 32'hC0A80002, 48'h0, MyIp, 16'h0800);
    push(KEnd, 48'h0, 32'h0);
    push(KReply, 48'h001122334455, 32'hC0A80002);
    push(KLook, 48'h0, 32'h0);
    send(28);
    idle(1);
    do_lookup(32'hC0A80002);
    idle(2);
    check("reply_req_held", {63'b0, arp_reply_req}, 64'h1);
    ack_reply();
    push(KLook, 48'h001122334455, 32'h1);
    do_lookup(32'hC0A80002);
    idle(2);

    // Reply to us with CRC error: end only, no write.
    build(16'd2, 48'hAABBCCDDEE01, 32'hC0A80009, MyMac, MyIp, 16'h0800);
    crc_error = 1'b1;
    push(KEnd, 48'h0, 32'h0);
    send(28);
    idle(2);
    crc_error = 1'b0;
    push(KLook, 48'h0, 32'h0);
    do_lookup(32'hC0A80009);
    idle(2);
    // Same reply, clean: found pulses and entry learnt.
    push(KEnd, 48'h0, 32'h0);
    push(KFound, 48'h0, 32'h0);
    send(28);
    idle(3);
    push(KLook, 48'hAABBCCDDEE01, 32'h1);
    do_lookup(32'hC0A80009);
    idle(2);

    // Flush coincident with an UPDATE write wins.
    build(16'd2, 48'h0000000000AA, 32'hC0A80044, 48'h0, MyIp, 16'h0800);
    push(KEnd, 48'h0, 32'h0);
    send(28);
    idle(1);
    cache_flush = 1'b1;
    idle(1);
    cache_flush = 1'b0;
    push(KLook, 48'h0, 32'h0);
    push(KLook, 48'h0, 32'h0);
    push(KLook, 48'h0, 32'h0);
    do_lookup(32'hC0A80002);
    do_lookup(32'hC0A80009);
    do_lookup(32'hC0A80044);
    idle(2);

    // Six distinct learners into four entries: first two evicted round-robin.
    for (int k = 1; k <= 6; k++) begin
      build(16'd2, 48'h100000000000 | 48'(k), 32'h0A000000 + 32'(k), 48'h0, MyIp, 16'h0800);
      push(KEnd, 48'h0, 32'h0);
      send(28);
      idle(3);
    end
    for (int k = 1; k <= 6; k++) begin
      if (k <= 2) push(KLook, 48'h0, 32'h0);
      else push(KLook, 48'h100000000000 | 48'(k), 32'h1);
      do_lookup(32'h0A000000 + 32'(k));
    end
    idle(2);

    // Known sender updates its MAC even when not addressed to us.
    build(16'd2, 48'h0000DEADBEEF, 32'h0A000003, 48'h0, 32'hC0A800FE, 16'h0800);
    push(KEnd, 48'h0, 32'h0);
    send(28);
    idle(3);
    push(KLook, 48'h0000DEADBEEF, 32'h1);
    push(KLook, 48'h100000000004, 32'h1);
    do_lookup(32'h0A000003);
    do_lookup(32'h0A000004);
    idle(2);

    // Sender IP zero is never learnt.
    build(16'd2, 48'h0000000000BB, 32'h0, 48'h0, MyIp, 16'h0800);
    push(KEnd, 48'h0, 32'h0);
    send(28);
    idle(3);
    push(KLook, 48'h0, 32'h0);
    push(KLook, 48'h0000DEADBEEF, 32'h1);
    do_lookup(32'h0);
    do_lookup(32'h0A000003);
    idle(2);

    // Discards: wrong PTYPE, short frame, truncated frame.
    build(16'd1, 48'h0000000000CC, 32'hC0A80033, 48'h0, MyIp, 16'h86DD);
    push(KEnd, 48'h0, 32'h0);
    send(28);
    idle(3);
    build(16'd1, 48'h0000000000CC, 32'hC0A80033, 48'h0, MyIp, 16'h0800);
    push(KEnd, 48'h0, 32'h0);
    send(20);
    idle(3);
    push(KEnd, 48'h0, 32'h0);
    send(70);
    idle(3);
    push(KLook, 48'h0, 32'h0);
    do_lookup(32'hC0A80033);
    idle(2);

    // Second request while reply pending is dropped.
    build(16'd1, 48'h0000000011AA, 32'hC0A80011, 48'h0, MyIp, 16'h0800);
    push(KEnd, 48'h0, 32'h0);
    push(KReply, 48'h0000000011AA, 32'hC0A80011);
    send(28);
    idle(3);
    build(16'd1, 48'h0000000022BB, 32'hC0A80022, 48'h0, MyIp, 16'h0800);
    push(KEnd, 48'h0, 32'h0);
    send(28);
    idle(3);
    check("pending_reply_ip", {32'b0, arp_reply_ip}, 64'hC0A80011);
    check("pending_reply_mac", {16'b0, arp_reply_mac}, 64'h0000000011AA);
    check("pending_reply_req", {63'b0, arp_reply_req}, 64'h1);
    ack_reply();

    // Reset mid-RECV with a reply pending: everything cleared, no end pulse.
    build(16'd1, 48'h0000000033CC, 32'hC0A80055, 48'h0, MyIp, 16'h0800);
    push(KEnd, 48'h0, 32'h0);
    push(KReply, 48'h0000000033CC, 32'hC0A80055);
    send(28);
    idle(3);
    arp_rx_req = 1'b1;
    idle(1);
    arp_rx_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      arp_rx_valid = 1'b1;
      arp_rx_data  = fb[i];
      idle(1);
    end
    rst = 1'b1;
    arp_rx_valid = 1'b0;
    #2;
    check_outputs_zero("midrst");
    idle(1);
    rst = 1'b0;
    idle(5);
    push(KLook, 48'h0, 32'h0);
    do_lookup(32'hC0A80055);
    idle(2);
    build(16'd1, 48'h0000000066DD, 32'hC0A80066, 48'h0, MyIp, 16'h0800);
    push(KEnd, 48'h0, 32'h0);
    push(KReply, 48'h0000000066DD, 32'hC0A80066);
    send(28);
    idle(3);
    ack_reply();

    idle(5);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
